// File: rtl/mode_display_hub.sv
// Board mode hub: GPIO sync/debounce/press-detect, N-mode cycling, HEX mux and latched alarm.
// Optional alarm blink on oHEX is enabled by defining MODE_DISP_BLINK_EN.
module mode_display_hub #(
  parameter int unsigned NUM_MODES  = 3,
  parameter int unsigned GPIO_W     = 4,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned ALARM_W    = 2,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    iCLK,
  input  logic                    iRSTn,
  input  logic [GPIO_W-1:0]       iGPIO,
  input  logic [NUM_MODES*42-1:0] iHEX_BUS,
  input  logic [ALARM_W-1:0]      iALARM,
  output logic [GPIO_W-2:0]       oKEY,
  output logic [GPIO_W-2:0]       oKEY_PULSE,
  output logic [2:0]              oMODE,
  output logic [NUM_MODES-1:0]    oEN,
  output logic [41:0]             oHEX,
  output logic                    oALARM,
  output logic [ALARM_W-1:0]      oALARM_SRC
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  if (NUM_MODES < 2 || NUM_MODES > 8 || GPIO_W < 2 || DEB_CYCLES < 1 || BLINK_DIV < 1)
  begin : g_param_check
    $error("mode_display_hub: illegal parameter value");
  end

  logic [GPIO_W-1:0]           r_sync1, r_sync2, r_stable, r_stable_prev;
  logic [GPIO_W-1:0][CntW-1:0] r_cnt;
  logic [GPIO_W-2:0]           r_key_pulse;
  logic [2:0]                  r_mode;
  logic [41:0]                 r_hex;
  logic                        r_alarm;
  logic [ALARM_W-1:0]          r_alarm_src;

  logic [GPIO_W-1:0] w_fall;
  logic              w_mode_press;
  logic              w_clr;
  logic [2:0]        w_mode_next;
  logic [41:0]       w_hex;

  // Stable levels idle high, so reset release can never look like a press.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_sync1       <= '1;
      r_sync2       <= '1;
      r_stable      <= '1;
      r_stable_prev <= '1;
      r_cnt         <= '0;
    end else begin
      r_sync1       <= iGPIO;
      r_sync2       <= r_sync1;
      r_stable_prev <= r_stable;
      for (int b = 0; b < GPIO_W; b++) begin
        if (r_sync2[b] == r_stable[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CntMax) begin
          r_stable[b] <= ~r_stable[b];
          r_cnt[b]    <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_fall       = r_stable_prev & ~r_stable;
    w_mode_press = w_fall[GPIO_W-1];
    w_clr        = |r_key_pulse;
    w_mode_next  = r_mode;
    if (w_mode_press) begin
      w_mode_next = (r_mode == 3'(NUM_MODES - 1)) ? 3'd0 : r_mode + 3'd1;
    end
  end

  always_comb begin
    w_hex = {6{7'b1000111}};
    for (int m = 0; m < NUM_MODES; m++) begin
      if (r_mode == 3'(m)) w_hex = iHEX_BUS[m*42 +: 42];
    end
  end

  // Key pulses are suppressed whenever the mode changes so they never reach the wrong module.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_key_pulse <= '0;
      r_mode      <= 3'd0;
      r_hex       <= '1;
      r_alarm     <= 1'b0;
      r_alarm_src <= '0;
    end else begin
      r_key_pulse <= w_mode_press ? '0 : w_fall[GPIO_W-2:0];
      r_mode      <= w_mode_next;
      r_hex       <= w_hex;
      if (|iALARM) begin
        r_alarm     <= 1'b1;
        r_alarm_src <= (w_clr ? '0 : r_alarm_src) | iALARM;
      end else if (w_clr) begin
        r_alarm     <= 1'b0;
        r_alarm_src <= '0;
      end
    end
  end

  always_comb begin
    oEN = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      oEN[m] = (r_mode == 3'(m));
    end
  end

  assign oKEY       = ~r_stable[GPIO_W-2:0];
  assign oKEY_PULSE = r_key_pulse;
  assign oMODE      = r_mode;
  assign oALARM     = r_alarm;
  assign oALARM_SRC = r_alarm_src;

`ifdef MODE_DISP_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_DIV) + 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  logic [BlinkW-1:0] r_blink_cnt;
  logic              r_blink_on;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (!r_alarm) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BlinkMax) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign oHEX = (r_alarm && !r_blink_on) ? '1 : r_hex;
`else
  assign oHEX = r_hex;
`endif

endmodule
